// File: rtl/result_writeback_dma.sv
// rtl/result_writeback_dma.sv - Writes result-buffer rows to memory as one AXI INCR burst per row
//
// Optional feature macro: RESULT_WRITEBACK_DMA_STATS_EN
//   defined   : stat_busy_cycles counts busy cycles (saturating, cleared on accepted start)
//   undefined : stat_busy_cycles tied to 0, no counter logic
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   start_pulse         : one-cycle job start, honoured only when idle
//   dest_addr           : AXI byte address of the first row
//   src_addr            : first result-buffer row
//   length              : number of rows to transfer (0 = empty job)
//   done_irq            : one-cycle job-complete pulse
//   busy                : job in progress
//   error               : sticky error flag for the last job (non-OKAY bresp)
//   buf_rd_addr/_en     : result-buffer read port, data returns one cycle later
//   buf_rd_data         : W lanes of DATA_WIDTH_ACCUM bits, lane 0 in the LSBs
//   awaddr/awlen/awvalid/awready : AXI write address channel
//   wdata/wlast/wvalid/wready    : AXI write data channel
//   bresp/bvalid/bready          : AXI write response channel
//   stat_busy_cycles    : busy-cycle statistic
//
// Parameter constraints (not checked here):
//   SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM must be a multiple of AXI_DATA_WIDTH,
//   and the resulting beat count must not exceed 256.

module result_writeback_dma #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM     = 32,
    parameter int ADDR_WIDTH           = 10,
    parameter int AXI_DATA_WIDTH       = 64
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start_pulse,
    input  logic [31:0]                                      dest_addr,
    input  logic [ADDR_WIDTH-1:0]                            src_addr,
    input  logic [15:0]                                      length,
    output logic                                             done_irq,
    output logic                                             busy,
    output logic                                             error,
    output logic [ADDR_WIDTH-1:0]                            buf_rd_addr,
    output logic                                             buf_rd_en,
    input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0] buf_rd_data,
    output logic [31:0]                                      awaddr,
    output logic [7:0]                                       awlen,
    output logic                                             awvalid,
    input  logic                                             awready,
    output logic [AXI_DATA_WIDTH-1:0]                        wdata,
    output logic                                             wlast,
    output logic                                             wvalid,
    input  logic                                             wready,
    input  logic [1:0]                                       bresp,
    input  logic                                             bvalid,
    output logic                                             bready,
    output logic [31:0]                                      stat_busy_cycles
);

    localparam int          ROW_W     = SYSTOLIC_ARRAY_WIDTH * DATA_WIDTH_ACCUM;
    localparam int          BEATS     = ROW_W / AXI_DATA_WIDTH;
    localparam logic [31:0] ROW_BYTES = 32'(ROW_W / 8);
    localparam logic [8:0]  LAST_BEAT = 9'(BEATS - 1);
    localparam logic [7:0]  AWLEN_VAL = 8'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_XFER,
        S_RESP,
        S_DONE
    } state_t;

    state_t             state;
    logic [31:0]        dest_ptr;   // AXI address of the current row
    logic [15:0]        rows_left;  // rows still to send, including the current one
    logic [ROW_W-1:0]   row_reg;    // current row; shifted down one beat per accepted beat
    logic [8:0]         beat_cnt;
    logic               aw_done;
    logic               w_done;
    logic               aw_fire;
    logic               w_fire;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

    // The beat on the bus is always the low slice of the shifting row register,
    // so lane 0 goes out first in the least-significant bits of beat 0.
    assign wdata = row_reg[AXI_DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            dest_ptr    <= 32'd0;
            rows_left   <= 16'd0;
            row_reg     <= '0;
            beat_cnt    <= 9'd0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            done_irq    <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            buf_rd_addr <= '0;
            buf_rd_en   <= 1'b0;
            awaddr      <= 32'd0;
            awlen       <= 8'd0;
            awvalid     <= 1'b0;
            wlast       <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
        end else begin
            done_irq <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_pulse) begin
                        dest_ptr    <= dest_addr;
                        buf_rd_addr <= src_addr;
                        rows_left   <= length;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        if (length == 16'd0) begin
                            state <= S_DONE;
                        end else begin
                            // rd_en is raised on entry so it is high for exactly the READ cycle
                            buf_rd_en <= 1'b1;
                            state     <= S_READ;
                        end
                    end
                end

                S_READ: begin
                    buf_rd_en <= 1'b0;
                    state     <= S_LOAD;
                end

                S_LOAD: begin
                    // Buffer data is valid in this cycle; both channels start together.
                    row_reg  <= buf_rd_data;
                    awaddr   <= dest_ptr;
                    awlen    <= AWLEN_VAL;
                    awvalid  <= 1'b1;
                    wvalid   <= 1'b1;
                    wlast    <= (LAST_BEAT == 9'd0);
                    beat_cnt <= 9'd0;
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                    state    <= S_XFER;
                end

                S_XFER: begin
                    if (aw_fire) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            w_done <= 1'b1;
                        end else begin
                            row_reg  <= row_reg >> AXI_DATA_WIDTH;
                            beat_cnt <= beat_cnt + 9'd1;
                            wlast    <= ((beat_cnt + 9'd1) == LAST_BEAT);
                        end
                    end
                    // Either channel may finish in the same cycle as the other.
                    if ((aw_done || aw_fire) && (w_done || (w_fire && wlast))) begin
                        bready <= 1'b1;
                        state  <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (bvalid && bready) begin
                        bready <= 1'b0;
                        if (bresp != 2'b00) begin
                            error <= 1'b1;
                            state <= S_DONE;
                        end else if (rows_left > 16'd1) begin
                            rows_left   <= rows_left - 16'd1;
                            dest_ptr    <= dest_ptr + ROW_BYTES;      // wraps mod 2^32
                            buf_rd_addr <= buf_rd_addr + 1'b1;        // wraps mod 2^ADDR_WIDTH
                            buf_rd_en   <= 1'b1;
                            state       <= S_READ;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    done_irq <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RESULT_WRITEBACK_DMA_STATS_EN
    logic [31:0] busy_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cycles <= 32'd0;
        end else if (state == S_IDLE && start_pulse) begin
            busy_cycles <= 32'd0;
        end else if (busy && busy_cycles != 32'hFFFF_FFFF) begin
            busy_cycles <= busy_cycles + 32'd1;
        end
    end

    assign stat_busy_cycles = busy_cycles;
`else
    assign stat_busy_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_result_writeback_dma.sv
// tb/tb_result_writeback_dma.sv - Table-driven scoreboard bench for result_writeback_dma

module tb_result_writeback_dma;

    localparam int W        = 16;
    localparam int D        = 32;
    localparam int AW       = 10;
    localparam int XD       = 64;
    localparam int ROW_BITS = W * D;
    localparam int BEATS    = ROW_BITS / XD;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start_pulse = 1'b0;
    logic [31:0]         dest_addr = 32'd0;
    logic [AW-1:0]       src_addr = '0;
    logic [15:0]         length = 16'd0;
    logic                done_irq;
    logic                busy;
    logic                error;
    logic [AW-1:0]       buf_rd_addr;
    logic                buf_rd_en;
    logic [ROW_BITS-1:0] buf_rd_data = '0;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic                awvalid;
    logic                awready = 1'b0;
    logic [XD-1:0]       wdata;
    logic                wlast;
    logic                wvalid;
    logic                wready = 1'b0;
    logic [1:0]          bresp = 2'b00;
    logic                bvalid = 1'b0;
    logic                bready;
    logic [31:0]         stat_busy_cycles;

    result_writeback_dma dut (
        .clk              (clk),
        .rst              (rst),
        .start_pulse      (start_pulse),
        .dest_addr        (dest_addr),
        .src_addr         (src_addr),
        .length           (length),
        .done_irq         (done_irq),
        .busy             (busy),
        .error            (error),
        .buf_rd_addr      (buf_rd_addr),
        .buf_rd_en        (buf_rd_en),
        .buf_rd_data      (buf_rd_data),
        .awaddr           (awaddr),
        .awlen            (awlen),
        .awvalid          (awvalid),
        .awready          (awready),
        .wdata            (wdata),
        .wlast            (wlast),
        .wvalid           (wvalid),
        .wready           (wready),
        .bresp            (bresp),
        .bvalid           (bvalid),
        .bready           (bready),
        .stat_busy_cycles (stat_busy_cycles)
    );

    always #5 clk = ~clk;

    // Deterministic buffer contents: every lane of every row differs.
    function automatic logic [ROW_BITS-1:0] row_bits(input logic [AW-1:0] a);
        logic [ROW_BITS-1:0] r;
        r = '0;
        for (int l = 0; l < W; l++)
            r[l*D +: D] = (32'(a) * 32'h0001_0003) ^ (32'(l) * 32'h0101_0101) ^ 32'hC3A5_0000;
        return r;
    endfunction

    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= row_bits(buf_rd_addr);
    end

    typedef struct {
        int          len;
        logic [9:0]  src;
        logic [31:0] dest;
        int          aw_delay;
        bit          w_toggle;
        int          err_row;     // row index answered with SLVERR, -1 for none
        int          restart_at;  // cycle at which a stray start is pulsed, -1 for none
    } vec_t;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [31:0]   aw_q[$];
    logic [XD:0]   w_q[$];
    logic [AW-1:0] rd_q[$];
    logic [1:0]    resp_q[$];
    int            bursts_pending = 0;
    bit            b_fire_pend = 0;
    int            aw_wait = 0;
    int            aw_delay = 0;
    bit            w_toggle = 0;
    int            done_cnt = 0;
    int            aw_fires = 0;
    int            aw_seen = 0;
    int            w_beats = 0;
    bit            aw_stall = 0;
    bit            w_stall = 0;
    logic [31:0]   aw_prev = '0;
    logic [XD:0]   w_prev = '0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: wait for the falling edge, drive the slave side, score handshakes
    // that will complete on the next rising edge.
    task automatic tick();
        logic [XD:0] wexp;
        @(negedge clk);
        if (rst) begin
            bvalid = 1'b0; b_fire_pend = 0; bursts_pending = 0; aw_wait = 0;
            awready = 1'b0; wready = 1'b0; aw_stall = 0; w_stall = 0;
            return;
        end
        if (b_fire_pend) begin
            bvalid = 1'b0;
            b_fire_pend = 0;
        end
        if (!bvalid && bursts_pending > 0) begin
            bursts_pending--;
            bvalid = 1'b1;
            if (resp_q.size() > 0) bresp = resp_q.pop_front();
            else bresp = 2'b00;
        end
        awready = (aw_wait >= aw_delay);
        wready  = w_toggle ? ~wready : 1'b1;

        if (aw_stall) begin
            chk("aw_hold_valid", 96'(awvalid), 96'd1);
            chk("aw_hold_addr", 96'(awaddr), 96'(aw_prev));
        end
        if (w_stall) begin
            chk("w_hold_valid", 96'(wvalid), 96'd1);
            chk("w_hold_data", 96'({wlast, wdata}), 96'(w_prev));
        end

        if (awvalid) aw_seen++;
        if (awvalid && awready) begin
            aw_fires++;
            aw_wait = 0;
            chk("aw_expected", 96'(aw_q.size() > 0), 96'd1);
            if (aw_q.size() > 0) chk("awaddr", 96'(awaddr), 96'(aw_q.pop_front()));
            chk("awlen", 96'(awlen), 96'(BEATS - 1));
        end else if (awvalid) begin
            aw_wait++;
        end
        aw_stall = awvalid && !awready;
        aw_prev  = awaddr;

        if (wvalid && wready) begin
            w_beats++;
            chk("w_expected", 96'(w_q.size() > 0), 96'd1);
            if (w_q.size() > 0) begin
                wexp = w_q.pop_front();
                chk("wbeat", 96'({wlast, wdata}), 96'(wexp));
            end
            if (wlast) bursts_pending++;
        end
        w_stall = wvalid && !wready;
        w_prev  = {wlast, wdata};

        if (bvalid && bready) b_fire_pend = 1;

        if (buf_rd_en) begin
            chk("rd_expected", 96'(rd_q.size() > 0), 96'd1);
            if (rd_q.size() > 0) chk("buf_rd_addr", 96'(buf_rd_addr), 96'(rd_q.pop_front()));
        end
        if (done_irq) done_cnt++;
    endtask

    task automatic push_exp(input vec_t v);
        int                  nrows;
        logic [AW-1:0]       a;
        logic [ROW_BITS-1:0] rb;
        nrows = (v.err_row >= 0) ? v.err_row + 1 : v.len;
        for (int r = 0; r < nrows; r++) begin
            a = v.src + AW'(r);
            rb = row_bits(a);
            rd_q.push_back(a);
            aw_q.push_back(v.dest + 32'(r) * 32'd64);
            for (int k = 0; k < BEATS; k++) w_q.push_back({(k == BEATS - 1), rb[k*XD +: XD]});
            resp_q.push_back((r == v.err_row) ? 2'b10 : 2'b00);
        end
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int t;
        int nrows;
        nrows = (v.err_row >= 0) ? v.err_row + 1 : v.len;
        push_exp(v);
        aw_delay = v.aw_delay; w_toggle = v.w_toggle;
        done_cnt = 0; aw_fires = 0;
        dest_addr = v.dest; src_addr = v.src; length = 16'(v.len); start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        chk({tag, "_busy"}, 96'(busy), 96'd1);
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            if (t == v.restart_at) begin
                dest_addr = 32'h9999_0000; src_addr = 10'd500; length = 16'd5; start_pulse = 1'b1;
            end else begin
                start_pulse = 1'b0;
            end
            tick();
            t++;
        end
        start_pulse = 1'b0;
        chk({tag, "_done_seen"}, 96'(done_cnt > 0), 96'd1);
        repeat (4) tick();
        chk({tag, "_done_count"}, 96'(done_cnt), 96'd1);
        chk({tag, "_error"}, 96'(error), 96'(v.err_row >= 0));
        chk({tag, "_busy_end"}, 96'(busy), 96'd0);
        chk({tag, "_aw_count"}, 96'(aw_fires), 96'(nrows));
        chk({tag, "_queues_empty"}, 96'(aw_q.size() + w_q.size() + rd_q.size() + resp_q.size()), 96'd0);
    endtask

    vec_t vecs[5];
    vec_t rv;

    initial begin
        int t;
        vecs[0] = '{len: 1, src: 10'd5,    dest: 32'h0000_1000, aw_delay: 0, w_toggle: 0, err_row: -1, restart_at: -1};
        vecs[1] = '{len: 3, src: 10'd1022, dest: 32'h0000_2000, aw_delay: 0, w_toggle: 0, err_row: -1, restart_at: -1};
        vecs[2] = '{len: 1, src: 10'd7,    dest: 32'h0000_3000, aw_delay: 5, w_toggle: 1, err_row: -1, restart_at: 3};
        vecs[3] = '{len: 4, src: 10'd100,  dest: 32'h0000_4000, aw_delay: 0, w_toggle: 0, err_row: 1,  restart_at: -1};
        vecs[4] = '{len: 2, src: 10'd1023, dest: 32'hFFFF_FFC0, aw_delay: 2, w_toggle: 1, err_row: -1, restart_at: -1};

        // Reset state
        repeat (2) tick();
        chk("reset_ctrl", 96'({done_irq, busy, error, buf_rd_en, awvalid, wlast, wvalid, bready}), 96'd0);
        chk("reset_addr", 96'({awaddr, awlen, buf_rd_addr}), 96'd0);
        chk("reset_wdata", 96'(wdata), 96'd0);
        chk("reset_stat", 96'(stat_busy_cycles), 96'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_job(vecs[i], $sformatf("vec%0d", i));

        // Empty job: done two cycles after start, no AXI traffic
        aw_seen = 0; done_cnt = 0;
        length = 16'd0; start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        chk("len0_cycle1", 96'(done_irq), 96'd0);
        tick();
        chk("len0_cycle2", 96'(done_irq), 96'd1);
        tick();
        chk("len0_cycle3", 96'(done_irq), 96'd0);
        repeat (3) tick();
        chk("len0_no_aw", 96'(aw_seen), 96'd0);
        chk("len0_busy", 96'(busy), 96'd0);
        chk("len0_done_count", 96'(done_cnt), 96'd1);

        // Reset in the middle of a burst
        rv = '{len: 1, src: 10'd3, dest: 32'h0000_6000, aw_delay: 0, w_toggle: 0, err_row: -1, restart_at: -1};
        push_exp(rv);
        aw_delay = 0; w_toggle = 0; w_beats = 0;
        dest_addr = rv.dest; src_addr = rv.src; length = 16'd1; start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        t = 0;
        while (w_beats < 4 && t < 200) begin
            tick();
            t++;
        end
        chk("midburst_reached", 96'(w_beats), 96'd4);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", 96'({done_irq, busy, error, buf_rd_en, awvalid, wlast, wvalid, bready}), 96'd0);
        chk("midrst_addr", 96'({awaddr, awlen, buf_rd_addr}), 96'd0);
        chk("midrst_wdata", 96'(wdata), 96'd0);
        aw_q.delete(); w_q.delete(); rd_q.delete(); resp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        run_job(vecs[0], "post_reset");

`ifdef RESULT_WRITEBACK_DMA_STATS_EN
        chk("stat_nonzero", 96'(stat_busy_cycles != 32'd0), 96'd1);
`else
        chk("stat_tied_zero", 96'(stat_busy_cycles), 96'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/result_writeback_dma.md
RESULT_WRITEBACK_DMA -- requirements
Module: result_writeback_dma

Interface
REQ-001 SYSTOLIC_ARRAY_WIDTH, 16, lanes per result row (W).
REQ-002 DATA_WIDTH_ACCUM, 32, bits per lane.
REQ-003 ADDR_WIDTH, 10, result-buffer row address width.
REQ-004 AXI_DATA_WIDTH, 64, AXI W beat width.
- W*DATA_WIDTH_ACCUM SHALL divide evenly by AXI_DATA_WIDTH.
- BEATS = W*DATA_WIDTH_ACCUM/AXI_DATA_WIDTH SHALL be ≤256.
- ROW_BYTES = W*DATA_WIDTH_ACCUM/8.
REQ-005 clk input 1: sole clock, rising edge.
REQ-006 rst input 1: asynchronous, active-high reset.
REQ-007 start_pulse input 1: one-cycle job start.
REQ-008 dest_addr input 32: AXI byte address of the first row.
REQ-009 src_addr input ADDR_WIDTH: first buffer row.
REQ-010 length input 16: rows to transfer.
REQ-011 done_irq output 1: one-cycle job-complete pulse.
REQ-012 busy output 1: job in progress.
REQ-013 error output 1: sticky error flag for the last job.
REQ-014 buf_rd_addr output ADDR_WIDTH: buffer read address.
REQ-015 buf_rd_en output 1: buffer read strobe.
REQ-016 buf_rd_data input W x DATA_WIDTH_ACCUM: row data, valid 1 cycle after buf_rd_en.
REQ-017 awaddr output 32: AXI write address.
REQ-018 awlen output 8: burst length minus one.
REQ-019 awvalid output 1: address valid.
REQ-020 awready input 1: address accepted.
REQ-021 wdata output AXI_DATA_WIDTH: write data beat.
REQ-022 wlast output 1: final beat of the burst.
REQ-023 wvalid output 1: data valid.
REQ-024 wready input 1: beat accepted.
REQ-025 bresp input 2: write response code.
REQ-026 bvalid input 1: response valid.
REQ-027 bready output 1: response accept.
REQ-028 stat_busy_cycles output 32: busy-cycle count (see Configuration).

Function
REQ-029 FSM states SHALL be IDLE, READ, LOAD, XFER, RESP, DONE.
- IDLE: start_pulse latches dest_addr, src_addr and length, clears error, sets busy, and goes to READ (or to DONE if length=0).
- start_pulse outside IDLE SHALL be ignored.
REQ-030 READ SHALL assert buf_rd_en for one cycle at the current row address.
- LOAD SHALL capture buf_rd_data into a W-lane row register, then go to XFER.
REQ-031 XFER: AW and W channels SHALL run concurrently, each with its own done flag.
- Each row SHALL be one INCR burst: awaddr = dest_addr + row_idx*ROW_BYTES, awlen = BEATS-1.
- Beat k SHALL carry row bits [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]; lane 0 sits in the least-significant bits of beat 0.
- wlast SHALL be asserted on beat BEATS-1.
- Once both channels complete, the FSM SHALL go to RESP.
REQ-032 Handshake rules:
- A valid SHALL NOT depend on its ready.
- Once asserted, awvalid/awaddr and wvalid/wdata/wlast SHALL hold until the matching ready.
- A transfer occurs only when valid and ready are both high in the same cycle.
REQ-033 RESP SHALL assert bready. On bvalid:
- bresp≠0: set error and go to DONE.
- else, if rows remain: increment the row index and buffer address, go to READ.
- else: go to DONE.
REQ-034 DONE SHALL pulse done_irq for one cycle, clear busy, and return to IDLE.
- With length=0, done_irq SHALL appear 2 cycles after start_pulse, with no AXI activity.
REQ-035 Wrap rules:
- Buffer address SHALL wrap modulo 2^ADDR_WIDTH.
- AXI address SHALL wrap modulo 2^32.
- Bursts crossing 4 KB boundaries are the software's responsibility.

Reset
REQ-036 While rst is high, the FSM SHALL be IDLE and all outputs 0, including mid-burst.
- An AXI transaction interrupted by reset is abandoned.
- The first start_pulse after rst deasserts SHALL be honoured.

Configuration
REQ-037 Macro RESULT_WRITEBACK_DMA_STATS_EN:
- Defined: stat_busy_cycles SHALL increment every cycle busy=1, SHALL saturate at 2^32-1, and SHALL clear on an accepted start_pulse.
- Undefined: stat_busy_cycles SHALL be tied to 0 and the counter logic SHALL be absent.

Verification (defaults; BEATS=8, ROW_BYTES=64)
REQ-038 length=1, src=5, dest=0x1000, readies held 1 -> buf_rd_addr=5; awaddr=0x1000, awlen=7; 8 beats, beat0={lane1,lane0}; wlast on beat 8; OKAY -> done_irq, error=0.
REQ-039 length=3, src=1022, dest=0x2000 -> buf_rd_addr 1022,1023,0; awaddr 0x2000,0x2040,0x2080; 24 beats; 1 done_irq.
REQ-040 awready delayed 5 cycles, wready toggling 1/0 -> awvalid/wdata stable while stalled; exactly 8 beats; correct order.
REQ-041 length=4, bresp=2'b10 on row 2 -> error=1, done_irq, no third AW, busy=0.
REQ-042 length=0 -> done_irq exactly 2 cycles after start, awvalid never 1; start during busy ignored.
REQ-043 rst pulsed during beat 4 -> all outputs 0 immediately; a new length=1 job completes normally; with STATS_EN, stat_busy_cycles is nonzero after a job.
